// File: rtl/class_hvec_pkg.sv
// -----------------------------------------------------------------------------
// class_hvec_pkg
// Shared constants, types and helpers for the class-hypervector sequencer.
//   - Geometry of the class ROM (frame width, class count, frames per class)
//     and the address widths derived from it.
//   - FSM state encoding and the (class, frame) beat tag.
//   - Helpers for walking the sweep order and flagging the last beats.
// -----------------------------------------------------------------------------
package class_hvec_pkg;

  localparam int DI_PARALLEL_W_BITS = 64;
  localparam int NUM_CLASSES        = 8;
  localparam int NUM_FRAMES         = 3;
  localparam int CLASS_ID_W         = $clog2(NUM_CLASSES);
  localparam int FRAME_IDX_W        = $clog2(NUM_FRAMES);
  // One extra bit so the class count can hold NUM_CLASSES itself.
  localparam int CLASS_CNT_W        = CLASS_ID_W + 1;

  localparam logic [FRAME_IDX_W-1:0] LAST_FRAME_IDX = FRAME_IDX_W'(NUM_FRAMES - 1);
  localparam logic [CLASS_CNT_W-1:0] MAX_CLASS_CNT  = CLASS_CNT_W'(NUM_CLASSES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } class_seq_state_t;

  typedef struct packed {
    logic [CLASS_ID_W-1:0]  class_id;
    logic [FRAME_IDX_W-1:0] frame_index;
  } class_beat_tag_t;

  // Successor in sweep order: frame index first, then class.
  function automatic class_beat_tag_t next_beat_tag(input class_beat_tag_t tag);
    class_beat_tag_t nxt;
    if (tag.frame_index == LAST_FRAME_IDX) begin
      nxt.class_id    = tag.class_id + CLASS_ID_W'(1);
      nxt.frame_index = '0;
    end else begin
      nxt.class_id    = tag.class_id;
      nxt.frame_index = tag.frame_index + FRAME_IDX_W'(1);
    end
    return nxt;
  endfunction

  function automatic logic is_last_frame(input class_beat_tag_t tag);
    return (tag.frame_index == LAST_FRAME_IDX);
  endfunction

  // Final beat of a sweep of n classes.
  function automatic logic is_last_class_beat(input class_beat_tag_t tag,
                                              input logic [CLASS_CNT_W-1:0] n);
    return (tag.frame_index == LAST_FRAME_IDX) &&
           ({1'b0, tag.class_id} == (n - CLASS_CNT_W'(1)));
  endfunction

  // Zero or out-of-range class counts fall back to a full sweep.
  function automatic logic [CLASS_CNT_W-1:0] legal_class_cnt(input logic [CLASS_CNT_W-1:0] cfg);
    logic [CLASS_CNT_W-1:0] n;
    if ((cfg == CLASS_CNT_W'(0)) || (cfg > MAX_CLASS_CNT)) begin
      n = MAX_CLASS_CNT;
    end else begin
      n = cfg;
    end
    return n;
  endfunction

endpackage

// File: rtl/class_hvec_seq.sv
// -----------------------------------------------------------------------------
// class_hvec_seq
// Walks the external class-hypervector ROM (class_hvec_gen) class by class,
// frame by frame, and streams every word over valid/ready with class/frame tags.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 begin a sweep (ignored while busy)
//   num_classes_cfg_i       classes to sweep, latched on accepted start
//   abort_i                 end the sweep early without a done pulse
//   busy_o, done_o          sweep in progress / one-cycle completion pulse
//   rom_frame_id_o/index_o  ROM address of the next beat to be loaded
//   rom_data_i              ROM word at that address
//   m_valid_o, m_ready_i    output handshake
//   m_data_o                registered frame data
//   m_class_id_o, m_frame_index_o, m_last_frame_o, m_last_class_o  beat tags
// -----------------------------------------------------------------------------
module class_hvec_seq
  import class_hvec_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [CLASS_CNT_W-1:0]        num_classes_cfg_i,
  input  logic                          abort_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [CLASS_ID_W-1:0]         rom_frame_id_o,
  output logic [FRAME_IDX_W-1:0]        rom_frame_index_o,
  input  logic [DI_PARALLEL_W_BITS-1:0] rom_data_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [DI_PARALLEL_W_BITS-1:0] m_data_o,
  output logic [CLASS_ID_W-1:0]         m_class_id_o,
  output logic [FRAME_IDX_W-1:0]        m_frame_index_o,
  output logic                          m_last_frame_o,
  output logic                          m_last_class_o
);

  class_seq_state_t              state_q, state_d;
  class_beat_tag_t               tag_q, tag_d;
  logic [CLASS_CNT_W-1:0]        n_q, n_d;
  logic [DI_PARALLEL_W_BITS-1:0] data_q, data_d;
  logic                          valid_q, valid_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          last_frame_q, last_frame_d;
  logic                          last_class_q, last_class_d;

  class_beat_tag_t               rom_ptr_s;
  logic [CLASS_CNT_W-1:0]        n_cfg_s;
  logic                          handshake_s;

  assign n_cfg_s     = legal_class_cnt(num_classes_cfg_i);
  assign handshake_s = valid_q & m_ready_i;

  // ROM pointer: first beat while idle, otherwise the beat after the current one.
  always_comb begin
    rom_ptr_s = '0;
    if (state_q == STREAM) begin
      rom_ptr_s = next_beat_tag(tag_q);
    end else begin
      rom_ptr_s = '0;
    end
  end

  // Next-state and output-register logic for the sweep FSM.
  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    n_d          = n_q;
    data_d       = data_q;
    valid_d      = valid_q;
    last_frame_d = last_frame_q;
    last_class_d = last_class_q;

    case (state_q)
      IDLE: begin
        // start beats abort here; abort alone is ignored in IDLE.
        if (start_i) begin
          state_d      = STREAM;
          n_d          = n_cfg_s;
          tag_d        = rom_ptr_s;
          data_d       = rom_data_i;
          valid_d      = 1'b1;
          last_frame_d = is_last_frame(rom_ptr_s);
          last_class_d = is_last_class_beat(rom_ptr_s, n_cfg_s);
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        // A beat handshaken together with abort still counts, but the sweep ends.
        if (abort_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (handshake_s) begin
          if (last_class_q) begin
            state_d = DONE;
            valid_d = 1'b0;
          end else begin
            tag_d        = rom_ptr_s;
            data_d       = rom_data_i;
            last_frame_d = is_last_frame(rom_ptr_s);
            last_class_d = is_last_class_beat(rom_ptr_s, n_q);
          end
        end else begin
          state_d = STREAM;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      n_q          <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      last_frame_q <= 1'b0;
      last_class_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      n_q          <= n_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      last_frame_q <= last_frame_d;
      last_class_q <= last_class_d;
    end
  end

  assign rom_frame_id_o    = rom_ptr_s.class_id;
  assign rom_frame_index_o = rom_ptr_s.frame_index;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign m_valid_o         = valid_q;
  assign m_data_o          = data_q;
  assign m_class_id_o      = tag_q.class_id;
  assign m_frame_index_o   = tag_q.frame_index;
  assign m_last_frame_o    = last_frame_q;
  assign m_last_class_o    = last_class_q;

endmodule

// File: tb/tb_class_hvec_seq.sv
// -----------------------------------------------------------------------------
// tb_class_hvec_seq
// Self-checking bench for class_hvec_seq with a randomly filled ROM table
// standing in for class_hvec_gen.
// -----------------------------------------------------------------------------
module tb_class_hvec_seq;
  import class_hvec_pkg::*;

  typedef logic [DI_PARALLEL_W_BITS+CLASS_ID_W+FRAME_IDX_W+1:0] beat_w_t;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          start;
  logic [CLASS_CNT_W-1:0]        num_classes_cfg;
  logic                          abort;
  logic                          busy;
  logic                          done;
  logic [CLASS_ID_W-1:0]         rom_frame_id;
  logic [FRAME_IDX_W-1:0]        rom_frame_index;
  logic [DI_PARALLEL_W_BITS-1:0] rom_data;
  logic                          m_valid;
  logic                          m_ready;
  logic [DI_PARALLEL_W_BITS-1:0] m_data;
  logic [CLASS_ID_W-1:0]         m_class_id;
  logic [FRAME_IDX_W-1:0]        m_frame_index;
  logic                          m_last_frame;
  logic                          m_last_class;

  logic [DI_PARALLEL_W_BITS-1:0] rom_tbl [0:NUM_CLASSES-1][0:3];
  beat_w_t                       cur_w;

  int n_checks = 0;
  int n_fail   = 0;

  beat_w_t got_q[$];
  int      got_cyc_q[$];
  beat_w_t exp_q[$];
  int      first_valid_cyc, done_cyc, done_cnt, busy_fall_cyc, stall_bad;
  bit      timed_out;

  class_hvec_seq dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .num_classes_cfg_i (num_classes_cfg),
    .abort_i           (abort),
    .busy_o            (busy),
    .done_o            (done),
    .rom_frame_id_o    (rom_frame_id),
    .rom_frame_index_o (rom_frame_index),
    .rom_data_i        (rom_data),
    .m_valid_o         (m_valid),
    .m_ready_i         (m_ready),
    .m_data_o          (m_data),
    .m_class_id_o      (m_class_id),
    .m_frame_index_o   (m_frame_index),
    .m_last_frame_o    (m_last_frame),
    .m_last_class_o    (m_last_class)
  );

  always #5 clk = ~clk;

  assign rom_data = rom_tbl[rom_frame_id][rom_frame_index];
  assign cur_w    = {m_data, m_class_id, m_frame_index, m_last_frame, m_last_class};

  // Expected beat list: every frame of every class, classes 0..N-1.
  task automatic build_exp(input logic [CLASS_CNT_W-1:0] cfg);
    int n;
    n = (cfg == 0 || cfg > NUM_CLASSES) ? NUM_CLASSES : int'(cfg);
    exp_q.delete();
    for (int c = 0; c < n; c++) begin
      for (int f = 0; f < NUM_FRAMES; f++) begin
        exp_q.push_back({rom_tbl[c][f], CLASS_ID_W'(c), FRAME_IDX_W'(f),
                         (f == NUM_FRAMES - 1), (f == NUM_FRAMES - 1 && c == n - 1)});
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0; num_classes_cfg = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs one sweep and records transferred beats; cycle 0 is the start cycle.
  // mode 0: always ready, 1: 1010 pattern with a 5-cycle stall at (3,1), 2: random.
  task automatic drive_sweep(input logic [CLASS_CNT_W-1:0] cfg, input int mode,
                             input int abort_idx, input int busy_start_cyc,
                             input logic [CLASS_CNT_W-1:0] busy_cfg);
    int cyc, stretch_left;
    bit stalled, stretch_done, r;
    beat_w_t held;
    got_q.delete(); got_cyc_q.delete();
    first_valid_cyc = -1; done_cyc = -1; done_cnt = 0; busy_fall_cyc = -1;
    stall_bad = 0; timed_out = 1'b0;
    stalled = 1'b0; stretch_left = 0; stretch_done = 1'b0; held = '0;
    num_classes_cfg = cfg; start = 1'b1; abort = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    while (1) begin
      start = 1'b0; abort = 1'b0;
      if (cyc == busy_start_cyc) begin
        start = 1'b1; num_classes_cfg = busy_cfg;
      end
      case (mode)
        0: r = 1'b1;
        1: begin
          if (!stretch_done && m_valid && m_class_id == 3'd3 && m_frame_index == 2'd1) begin
            stretch_left = 5; stretch_done = 1'b1;
          end
          if (stretch_left > 0) begin
            r = 1'b0; stretch_left--;
          end else begin
            r = (cyc % 2 == 1);
          end
        end
        default: r = 1'($urandom_range(0, 1));
      endcase
      m_ready = r;
      if (m_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (stalled && cur_w !== held) stall_bad++;
        if (r) begin
          got_q.push_back(cur_w);
          got_cyc_q.push_back(cyc);
          if (got_q.size() - 1 == abort_idx) abort = 1'b1;
          stalled = 1'b0;
        end else begin
          held = cur_w; stalled = 1'b1;
        end
      end else if (stalled) begin
        stall_bad++; stalled = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (!busy) begin
        busy_fall_cyc = cyc;
        break;
      end
      if (cyc >= 400) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; abort = 1'b0; m_ready = 1'b0;
    if (timed_out) do_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({m_valid, busy, done, m_last_frame, m_last_class} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {m_valid, busy, done, m_last_frame, m_last_class});
    end
    n_checks++;
    if ({m_data, m_class_id, m_frame_index} !== '0) begin
      n_fail++;
      $display("FAIL reset_data_tags: got %h/%0d/%0d expected 0/0/0", m_data, m_class_id, m_frame_index);
    end
    n_checks++;
    if ({rom_frame_id, rom_frame_index} !== '0) begin
      n_fail++;
      $display("FAIL reset_rom_ptr: got %0d/%0d expected 0/0", rom_frame_id, rom_frame_index);
    end
  endtask

  task automatic test_full_sweep();
    drive_sweep(4'd8, 0, -1, -1, 4'd0);
    build_exp(4'd8);
    n_checks++;
    if (timed_out !== 1'b0) begin n_fail++; $display("FAIL full_timeout: got 1 expected 0"); end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL full_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i] || got_cyc_q[i] !== i + 1) begin
        n_fail++;
        $display("FAIL full_beat[%0d]: got %h at cycle %0d expected %h at cycle %0d",
                 i, got_q[i], got_cyc_q[i], exp_q[i], i + 1);
      end
    end
    n_checks++;
    if (done_cyc !== 25 || done_cnt !== 1) begin
      n_fail++; $display("FAIL full_done: got cycle %0d count %0d expected cycle 25 count 1", done_cyc, done_cnt);
    end
    n_checks++;
    if (busy_fall_cyc !== 26) begin
      n_fail++; $display("FAIL full_busy_fall: got %0d expected 26", busy_fall_cyc);
    end
  endtask

  task automatic test_backpressure();
    drive_sweep(4'd8, 1, -1, -1, 4'd0);
    build_exp(4'd8);
    n_checks++;
    if (got_q.size() !== exp_q.size() || timed_out) begin
      n_fail++; $display("FAIL bp_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (stall_bad !== 0) begin
      n_fail++; $display("FAIL bp_stall_stable: got %0d violations expected 0", stall_bad);
    end
    n_checks++;
    if (done_cnt !== 1) begin
      n_fail++; $display("FAIL bp_done: got %0d pulses expected 1", done_cnt);
    end
  endtask

  task automatic test_config();
    logic [CLASS_CNT_W-1:0] cfgs [3];
    cfgs[0] = 4'd2; cfgs[1] = 4'd0; cfgs[2] = 4'd9;
    for (int k = 0; k < 3; k++) begin
      drive_sweep(cfgs[k], 0, -1, -1, 4'd0);
      build_exp(cfgs[k]);
      n_checks++;
      if (got_q.size() !== exp_q.size() || timed_out) begin
        n_fail++; $display("FAIL cfg%0d_count: got %0d expected %0d", cfgs[k], got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL cfg%0d_beat[%0d]: got %h expected %h", cfgs[k], i, got_q[i], exp_q[i]);
        end
      end
      n_checks++;
      if (done_cnt !== 1 || done_cyc !== exp_q.size() + 1) begin
        n_fail++;
        $display("FAIL cfg%0d_done: got cycle %0d count %0d expected cycle %0d count 1",
                 cfgs[k], done_cyc, done_cnt, exp_q.size() + 1);
      end
    end
  endtask

  task automatic test_random();
    logic [CLASS_CNT_W-1:0] cfg;
    for (int k = 0; k < 4; k++) begin
      cfg = CLASS_CNT_W'($urandom_range(0, 15));
      drive_sweep(cfg, 2, -1, -1, 4'd0);
      build_exp(cfg);
      n_checks++;
      if (got_q.size() !== exp_q.size() || timed_out || stall_bad != 0 || done_cnt != 1) begin
        n_fail++;
        $display("FAIL rand%0d_summary: got beats %0d stall %0d done %0d expected beats %0d stall 0 done 1",
                 k, got_q.size(), stall_bad, done_cnt, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand%0d_beat[%0d]: got %h expected %h", k, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_abort();
    int abort_idx;
    abort_idx = 4 * NUM_FRAMES + 1;  // beat (4,1)
    drive_sweep(4'd8, 0, abort_idx, -1, 4'd0);
    build_exp(4'd8);
    n_checks++;
    if (got_q.size() !== abort_idx + 1 || timed_out) begin
      n_fail++; $display("FAIL abort_count: got %0d expected %0d", got_q.size(), abort_idx + 1);
    end
    for (int i = 0; i <= abort_idx && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL abort_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (done_cnt !== 0 || m_valid !== 1'b0 || busy_fall_cyc !== abort_idx + 2) begin
      n_fail++;
      $display("FAIL abort_end: got done %0d valid %b idle_cycle %0d expected done 0 valid 0 idle_cycle %0d",
               done_cnt, m_valid, busy_fall_cyc, abort_idx + 2);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_done: got %b expected 0", done);
    end
    drive_sweep(4'd8, 0, -1, -1, 4'd0);
    n_checks++;
    if (got_q.size() !== exp_q.size() || got_q[0] !== exp_q[0] || got_cyc_q[0] !== 1) begin
      n_fail++; $display("FAIL abort_replay: got %0d beats first %h expected %0d beats first %h",
                         got_q.size(), got_q[0], exp_q.size(), exp_q[0]);
    end
  endtask

  task automatic test_start_while_busy();
    drive_sweep(4'd8, 0, -1, 5, 4'd2);
    build_exp(4'd8);
    n_checks++;
    if (got_q.size() !== exp_q.size() || done_cnt !== 1 || timed_out) begin
      n_fail++; $display("FAIL busy_start_len: got %0d beats %0d done expected %0d beats 1 done",
                         got_q.size(), done_cnt, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL busy_start_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    num_classes_cfg = 4'd8; start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (m_valid && m_class_id == 3'd2 && m_frame_index == 2'd0) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL rstmid_reach: got no beat (2,0) expected beat (2,0)");
    end
    m_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({m_valid, busy, done, m_class_id, m_frame_index} !== '0) begin
      n_fail++; $display("FAIL rstmid_state: got valid %b busy %b done %b tag %0d/%0d expected all 0",
                         m_valid, busy, done, m_class_id, m_frame_index);
    end
    start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (m_valid !== 1'b1 || m_class_id !== 3'd0 || m_frame_index !== 2'd0 || m_data !== rom_tbl[0][0]) begin
      n_fail++; $display("FAIL rstmid_restart: got valid %b tag %0d/%0d data %h expected valid 1 tag 0/0 data %h",
                         m_valid, m_class_id, m_frame_index, m_data, rom_tbl[0][0]);
    end
    do_reset();
  endtask

  initial begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      for (int f = 0; f < 4; f++) begin
        rom_tbl[c][f] = {$urandom, $urandom};
      end
    end
    test_reset();
    test_full_sweep();
    test_backpressure();
    test_config();
    test_random();
    test_abort();
    test_start_while_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/class_hvec_seq.md
Name: class_hvec_seq

Overview:
Sequencer for the class-hypervector ROM (class_hvec_gen), which is a combinational lookup addressed by frame_id and frame_index. On start, it walks class IDs 0..N-1 and frames 0..NUM_FRAMES-1 in order. It registers each ROM word and streams it over a valid/ready interface to the similarity/associative-search stage, tagging each beat with its class and frame. It sits between the inference control FSM and the similarity datapath.

Parameters:
DI_PARALLEL_W_BITS, 64, width of one class-vector frame (ROM word).
NUM_CLASSES, 8, number of classes stored in the ROM.
NUM_FRAMES, 3, frames per class vector (D = NUM_FRAMES*DI_PARALLEL_W_BITS).
CLASS_ID_W, 3, $clog2(NUM_CLASSES); ROM frame_id width.
FRAME_IDX_W, 2, $clog2(NUM_FRAMES); ROM frame_index width.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
start  in  1  single-cycle request to begin a sweep; ignored while busy.
num_classes_cfg  in  CLASS_ID_W+1  number of classes to sweep; latched on accepted start.
abort  in  1  terminates the sweep; no done pulse.
busy  out  1  high from the cycle after an accepted start until return to IDLE.
done  out  1  one-cycle pulse after the last beat is accepted.
rom_frame_id  out  CLASS_ID_W  to class_hvec_gen.frame_id.
rom_frame_index  out  FRAME_IDX_W  to class_hvec_gen.frame_index.
rom_data  in  DI_PARALLEL_W_BITS  from class_hvec_gen.class_vec_out.
m_valid  out  1  output beat valid.
m_ready  in  1  consumer ready.
m_data  out  DI_PARALLEL_W_BITS  registered frame data.
m_class_id  out  CLASS_ID_W  class of current beat.
m_frame_index  out  FRAME_IDX_W  frame of current beat.
m_last_frame  out  1  beat is frame NUM_FRAMES-1 of its class.
m_last_class  out  1  beat is the final beat of the sweep.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE. busy, done, m_valid, m_last_frame and m_last_class are 0. m_data, m_class_id, m_frame_index and the internal counters are 0.
- FSM states: IDLE, STREAM, DONE.
- IDLE -> STREAM:
  - Happens on start=1.
  - Latch N = num_classes_cfg. If num_classes_cfg is 0 or greater than NUM_CLASSES, N = NUM_CLASSES.
  - Register the ROM word at (0,0) into m_data.
  - m_valid=1 in the next cycle, so latency start -> first valid beat is 1 cycle.
- ROM addressing: rom_frame_id and rom_frame_index are combinational from the "next beat" pointer.
  - In IDLE the pointer is (0,0).
  - In STREAM it is the successor of the current beat.
  - m_data is loaded from rom_data on the start cycle and on every handshake that is not the last beat.
- Handshake:
  - A beat transfers when m_valid && m_ready.
  - While m_valid && !m_ready, m_data and all tags are held stable.
  - Back-to-back transfers sustain 1 beat/cycle.
- Sweep ordering: frame index increments first. It wraps NUM_FRAMES-1 -> 0 and the class ID then increments. The sweep emits N*NUM_FRAMES beats.
- Tag flags: m_last_frame = (m_frame_index == NUM_FRAMES-1). m_last_class = m_last_frame && (m_class_id == N-1).
- STREAM -> DONE: on handshake of the m_last_class beat. m_valid drops in the next cycle.
- DONE: done=1 for exactly one cycle, busy=1, then DONE -> IDLE unconditionally.
- busy: 1 in STREAM and DONE.
- start while busy: ignored; no re-latch of N.
- abort:
  - In STREAM, abort forces IDLE next cycle with m_valid=0 and no done pulse.
  - If abort and a handshake coincide, the beat counts as transferred but the sweep still ends without done.
  - abort in IDLE or DONE is ignored; a pending done still pulses.
- start and abort together in IDLE: start wins.
- rst mid-sweep: immediate return to reset values next cycle; no done.

Decomposition:
- Package class_hvec_pkg holds:
  - Constants DI_PARALLEL_W_BITS, NUM_CLASSES and NUM_FRAMES, with derived widths.
  - typedef enum logic [1:0] {IDLE, STREAM, DONE} class_seq_state_t.
  - typedef struct {class_id, frame_index} class_beat_tag_t.
- No sub-module is needed: the ROM stays external (class_hvec_gen), instantiated alongside by the parent.
- An optional wrapper, class_hvec_stream_top, ties class_hvec_seq to class_hvec_gen for the testbench.

Test Plan:
1. Full sweep, m_ready=1, num_classes_cfg=8, start at cycle 0:
   - Beats at cycles 1..24 in order (0,0),(0,1),(0,2),(1,0)..(7,2).
   - m_data matches the ROM word for each (class,frame).
   - m_last_frame on every third beat; m_last_class only at cycle 24.
   - done at cycle 25; busy falls at cycle 26.
2. Backpressure, m_ready toggling 1010… plus a 5-cycle low stretch mid-class 3:
   - m_data and tags are stable while stalled.
   - No beat is lost or duplicated; the sequence is identical to test 1.
3. Partial and illegal config:
   - num_classes_cfg=2 -> 6 beats, m_last_class on (1,2), then done.
   - num_classes_cfg=0 or 9 -> 24 beats.
4. Abort at beat (4,1) with m_ready=1 in the same cycle:
   - (4,1) is transferred, then m_valid=0 and state IDLE.
   - done stays 0; a new start replays from (0,0).
5. start pulsed while busy, with a different num_classes_cfg:
   - Ignored; the sweep length is unchanged.
6. rst asserted during beat (2,0) with m_ready=0:
   - Next cycle m_valid=0, busy=0, done=0, tags 0.
   - A start after rst deasserts gives its first beat (0,0) one cycle later.
